// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - four-digit multiplexed seven-segment scan driver
//
// Purpose: scans four hex digits onto a common-anode 7-segment display. Each
// digit owns a slot of 2^SCAN_BITS cycles. The first BLANK_CYC cycles of every
// slot have all anodes off. New value/dp data is staged in a pending register.
// It is promoted to the display register only at a frame boundary, so a frame
// never shows a mix of old and new digits.
//
// Parameters:
//   SCAN_BITS  width of the per-digit slot counter (slot = 2^SCAN_BITS cycles, >= 2)
//   BLANK_CYC  anti-ghosting blank cycles at the start of each slot
//
// Ports:
//   clk    in   system clock, rising edge
//   rst    in   synchronous active-high reset
//   value  in   16 bits, four hex nibbles, value[3:0] = digit 0 (rightmost)
//   dp     in   4 bits, decimal point per digit, 1 = lit
//   load   in   single-cycle strobe capturing value/dp
//   ack    out  one-cycle pulse after captured data becomes displayed data
//   frame  out  one-cycle pulse on the last cycle of each digit-3 slot
//   seg    out  active-low cathodes {dp,g,f,e,d,c,b,a}
//   an     out  active-low anodes, an[i] enables digit i
//
// Optional feature: define SEG_BLANK_LZ_EN to blank leading-zero digits 1..3.

module seg_scan_driver #(
  parameter int SCAN_BITS = 17,
  parameter int BLANK_CYC = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic [3:0]  dp,
  input  logic        load,
  output logic        ack,
  output logic        frame,
  output logic [7:0]  seg,
  output logic [3:0]  an
);

  localparam logic [SCAN_BITS-1:0] CNT_LAST  = {SCAN_BITS{1'b1}};
  localparam logic [SCAN_BITS-1:0] CNT_PRE   = {{(SCAN_BITS-1){1'b1}}, 1'b0};
  localparam logic [SCAN_BITS-1:0] BLANK_LIM = SCAN_BITS'(BLANK_CYC);

  logic [SCAN_BITS-1:0] cnt_q, cnt_d;
  logic [1:0]           dig_q, dig_d;
  logic [15:0]          disp_val_q, pend_val_q;
  logic [3:0]           disp_dp_q, pend_dp_q;
  logic                 pend_q;
  logic                 ack_q, frame_q;
  logic [7:0]           seg_q, seg_d;
  logic [3:0]           an_q, an_d;
  logic [3:0]           nib;
  logic                 lz_blank;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0:    hex7 = 7'h40;
      4'h1:    hex7 = 7'h79;
      4'h2:    hex7 = 7'h24;
      4'h3:    hex7 = 7'h30;
      4'h4:    hex7 = 7'h19;
      4'h5:    hex7 = 7'h12;
      4'h6:    hex7 = 7'h02;
      4'h7:    hex7 = 7'h78;
      4'h8:    hex7 = 7'h00;
      4'h9:    hex7 = 7'h10;
      4'hA:    hex7 = 7'h08;
      4'hB:    hex7 = 7'h03;
      4'hC:    hex7 = 7'h46;
      4'hD:    hex7 = 7'h21;
      4'hE:    hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  always_comb begin
    cnt_d    = cnt_q + 1'b1;
    dig_d    = (cnt_q == CNT_LAST) ? dig_q + 2'd1 : dig_q;
    nib      = disp_val_q[{dig_q, 2'b00} +: 4];
    lz_blank = 1'b0;
`ifdef SEG_BLANK_LZ_EN
    // A digit is dark when it and every digit to its left are zero without a dp.
    case (dig_q)
      2'd1:    lz_blank = (disp_val_q[15:4]  == 12'd0) && !disp_dp_q[1];
      2'd2:    lz_blank = (disp_val_q[15:8]  == 8'd0)  && !disp_dp_q[2];
      2'd3:    lz_blank = (disp_val_q[15:12] == 4'd0)  && !disp_dp_q[3];
      default: lz_blank = 1'b0;
    endcase
`endif
    if ((cnt_q < BLANK_LIM) || lz_blank) begin
      an_d  = 4'hF;
      seg_d = 8'hFF;
    end else begin
      an_d  = ~(4'b0001 << dig_q);
      seg_d = {~disp_dp_q[dig_q], hex7(nib)};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      dig_q      <= 2'd0;
      disp_val_q <= 16'd0;
      disp_dp_q  <= 4'd0;
      pend_val_q <= 16'd0;
      pend_dp_q  <= 4'd0;
      pend_q     <= 1'b0;
      ack_q      <= 1'b0;
      frame_q    <= 1'b0;
      seg_q      <= 8'hFF;
      an_q       <= 4'hF;
    end else begin
      cnt_q   <= cnt_d;
      dig_q   <= dig_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      // Raised one cycle early so frame_q is high exactly in the last digit-3 cycle.
      frame_q <= (dig_q == 2'd3) && (cnt_q == CNT_PRE);
      ack_q   <= 1'b0;
      if (frame_q) begin
        // Boundary: a coincident load bypasses the pending register.
        if (load) begin
          disp_val_q <= value;
          disp_dp_q  <= dp;
          ack_q      <= 1'b1;
        end else if (pend_q) begin
          disp_val_q <= pend_val_q;
          disp_dp_q  <= pend_dp_q;
          ack_q      <= 1'b1;
        end
        pend_q <= 1'b0;
      end else if (load) begin
        pend_val_q <= value;
        pend_dp_q  <= dp;
        pend_q     <= 1'b1;
      end
    end
  end

  assign ack   = ack_q;
  assign frame = frame_q;
  assign seg   = seg_q;
  assign an    = an_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb/tb_seg_scan_driver.sv - randomized self-checking bench for seg_scan_driver

module tb_seg_scan_driver;

  localparam int SB    = 4;
  localparam int BC    = 2;
  localparam int SLOT  = 16;
  localparam int FRAME = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = 16'd0;
  logic [3:0]  dp = 4'd0;
  logic        ack, frame;
  logic [7:0]  seg;
  logic [3:0]  an;

  seg_scan_driver #(.SCAN_BITS(SB), .BLANK_CYC(BC)) dut (
    .clk(clk), .rst(rst), .value(value), .dp(dp), .load(load),
    .ack(ack), .frame(frame), .seg(seg), .an(an)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // Reference state: p = cycles since reset release, plus displayed / pending data.
  int          p;
  logic [15:0] m_disp_v, m_pend_v;
  logic [3:0]  m_disp_d, m_pend_d;
  bit          m_pend;
  bit          exp_ack;
  logic [7:0]  exp_seg;
  logic [3:0]  exp_an;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0h expected %0h p=%0d t=%0t", tag, obs, exp, p, $time);
    end
  endtask

  // What the display should show for counter position pos with current data.
  function automatic logic [11:0] expect_outputs(input int pos);
    int c, d;
    logic [3:0] n;
    bit blank;
    c = pos % SLOT;
    d = (pos / SLOT) % 4;
    n = 4'((m_disp_v >> (4 * d)) & 16'hF);
    blank = (c < BC);
`ifdef SEG_BLANK_LZ_EN
    if (d > 0 && (m_disp_v >> (4 * d)) == 16'd0 && !m_disp_d[d]) blank = 1'b1;
`endif
    if (blank) return {4'hF, 8'hFF};
    return {4'hF & ~(4'b0001 << d), ~m_disp_d[d], hex_tab[n][6:0]};
  endfunction

  task automatic step(input bit do_load, input logic [15:0] v, input logic [3:0] d);
    logic [11:0] nxt;
    bit boundary;
    check("seg", seg, exp_seg);
    check("an", an, exp_an);
    check("ack", ack, exp_ack);
    check("frame", frame, (p % FRAME) == FRAME - 1);
    boundary = (p % FRAME) == FRAME - 1;
    load  = do_load;
    value = v;
    dp    = d;
    nxt = expect_outputs(p);
    exp_an  = nxt[11:8];
    exp_seg = nxt[7:0];
    exp_ack = 1'b0;
    if (boundary) begin
      if (do_load) begin
        m_disp_v = v; m_disp_d = d; exp_ack = 1'b1;
      end else if (m_pend) begin
        m_disp_v = m_pend_v; m_disp_d = m_pend_d; exp_ack = 1'b1;
      end
      m_pend = 1'b0;
    end else if (do_load) begin
      m_pend_v = v; m_pend_d = d; m_pend = 1'b1;
    end
    p++;
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 16'($urandom), 4'($urandom));
  endtask

  task automatic run_until(input int target);
    for (int k = 0; k < 2 * FRAME && (p % FRAME) != target; k++) idle();
  endtask

  task automatic apply_reset(input int n, input bit with_load);
    rst   = 1'b1;
    load  = with_load;
    value = 16'hBEEF;
    dp    = 4'hF;
    @(negedge clk);
    for (int k = 0; k < n; k++) begin
      check("rst_seg", seg, 8'hFF);
      check("rst_an", an, 4'hF);
      check("rst_ack", ack, 1'b0);
      check("rst_frame", frame, 1'b0);
      @(negedge clk);
    end
    rst  = 1'b0;
    load = 1'b0;
    m_disp_v = 16'd0; m_disp_d = 4'd0;
    m_pend_v = 16'd0; m_pend_d = 4'd0; m_pend = 1'b0;
    exp_ack = 1'b0; exp_seg = 8'hFF; exp_an = 4'hF;
    p = 0;
  endtask

  initial begin
    apply_reset(3, 1'b1);

    // Power-up: digit 0 shows 0 after the blank window, frames every 64 cycles.
    run_until(3);
    check("boot_an", an, 4'hE);
    check("boot_seg", seg, 8'hC0);
    for (int k = 0; k < 140; k++) idle();

    // Mid-frame load is held until the boundary.
    run_until(20);
    step(1'b1, 16'h1A8F, 4'b0100);
    run_until(63);
    idle();
    run_until(40);
    check("d2_seg", seg, 8'h08);
    check("d2_an", an, 4'hB);
    run_until(56);
    check("d3_seg", seg, 8'hF9);

    // Two loads in one frame: last wins.
    run_until(10);
    step(1'b1, 16'h1111, 4'h0);
    run_until(30);
    step(1'b1, 16'h2222, 4'h0);
    run_until(63);
    idle();
    run_until(10);
    check("last_wins_seg", seg, 8'hA4);
    check("last_wins_an", an, 4'hE);

    // Load coincident with the frame boundary.
    run_until(63);
    step(1'b1, 16'h0005, 4'h0);
    run_until(8);
    check("lz_d0_seg", seg, 8'h92);
    run_until(56);
`ifdef SEG_BLANK_LZ_EN
    check("lz_d3_an", an, 4'hF);
`else
    check("lz_d3_an", an, 4'h7);
    check("lz_d3_seg", seg, 8'hC0);
`endif
    for (int k = 0; k < 70; k++) idle();

    // Reset mid digit-2 slot with a load pending, load held during reset.
    run_until(35);
    step(1'b1, 16'h7777, 4'hA);
    run_until(40);
    apply_reset(2, 1'b1);
    for (int k = 0; k < 140; k++) idle();

    // Randomized traffic, biased toward leading zeros and boundary loads.
    for (int i = 0; i < 3000; i++) begin
      bit ld;
      logic [15:0] v;
      logic [3:0] d;
      if (i == 1500) apply_reset(3, 1'b1);
      v = 16'($urandom) >> (4 * $urandom_range(0, 3));
      d = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      if ((p % FRAME) == FRAME - 1) ld = ($urandom_range(0, 2) == 0);
      else ld = ($urandom_range(0, 29) == 0);
      step(ld, v, d);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
